// File: rtl/pulse_mon_pkg.sv
// rtl/pulse_mon_pkg.sv - shared state encoding and window helper for pulse_period_monitor
package pulse_mon_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // Inclusive window [period-tol, period+tol], written without subtraction to avoid underflow.
    function automatic logic in_window(input logic [31:0] interval,
                                       input logic [31:0] period,
                                       input logic [31:0] tol);
        return ((interval + tol) >= period) && (interval <= (period + tol));
    endfunction

endpackage

// File: rtl/pulse_interval_ctr.sv
// rtl/pulse_interval_ctr.sv - saturating pulse-to-pulse interval counter with timeout detect
module pulse_interval_ctr #(
    parameter int W      = 16,
    parameter int PERIOD = 17501,
    parameter int TOL    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         sig,
    output logic [W-1:0] interval,
    output logic         pulse,
    output logic         timeout
);

    localparam logic [W:0] LIMIT = (W+1)'(PERIOD + TOL);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        interval = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        pulse    = run & sig;
        timeout  = run & ~sig & ({1'b0, interval} > LIMIT);
        cnt_d    = (run && !sig) ? interval : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pulse_period_monitor.sv
// rtl/pulse_period_monitor.sv - period lock monitor for generator pulses; PULSE_MON_STICKY_ERR_EN makes error flags sticky
module pulse_period_monitor
    import pulse_mon_pkg::*;
#(
    parameter int N        = 17500,
    parameter int CBITS    = 15,
    parameter int TOL      = 2,
    parameter int LOCK_CNT = 3,
    parameter int MBITS    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    input  logic             clr,
    output logic             locked,
    output logic             err_early,
    output logic             err_late,
    output logic [CBITS:0]   period,
    output logic [MBITS-1:0] miss_cnt
);

    localparam int PERIOD = N + 1;
    localparam int W      = CBITS + 1;
    localparam int GW     = $clog2(LOCK_CNT + 1);

    state_e           state_q, state_d;
    logic [GW-1:0]    good_q, good_d;
    logic             locked_q, locked_d;
    logic             err_early_q, err_early_d;
    logic             err_late_q, err_late_d;
    logic [W-1:0]     period_q, period_d;
    logic [MBITS-1:0] miss_cnt_q, miss_cnt_d;

    logic [W-1:0] interval;
    logic         pulse;
    logic         timeout;
    logic         win;
    logic         early_evt;
    logic         late_evt;

    pulse_interval_ctr #(.W(W), .PERIOD(PERIOD), .TOL(TOL)) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .run      (state_q != SEARCH),
        .sig      (sig),
        .interval (interval),
        .pulse    (pulse),
        .timeout  (timeout)
    );

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        period_d  = period_q;
        early_evt = 1'b0;
        late_evt  = 1'b0;
        win       = in_window(32'(interval), 32'(PERIOD), 32'(TOL));

        if (pulse) begin
            period_d = interval;
        end

        case (state_q)
            SEARCH: begin
                if (sig) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (pulse) begin
                    if (!win) begin
                        good_d = '0;
                    end else if (32'(good_q) + 32'd1 == 32'(LOCK_CNT)) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end else if (timeout) begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            end
            LOCKED: begin
                // A late pulse landing on the timeout cycle drops lock quietly; only a true gap counts as a miss.
                if (pulse) begin
                    if (!win) begin
                        early_evt = (32'(interval) < 32'(PERIOD - TOL));
                        state_d   = ACQUIRE;
                        good_d    = '0;
                    end
                end else if (timeout) begin
                    late_evt = 1'b1;
                    state_d  = SEARCH;
                    good_d   = '0;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);

        if (clr) begin
            miss_cnt_d = '0;
        end else if (late_evt && !(&miss_cnt_q)) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end

`ifdef PULSE_MON_STICKY_ERR_EN
        err_early_d = early_evt | (err_early_q & ~clr);
        err_late_d  = late_evt  | (err_late_q  & ~clr);
`else
        err_early_d = early_evt;
        err_late_d  = late_evt;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SEARCH;
            good_q      <= '0;
            locked_q    <= 1'b0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
            period_q    <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            locked_q    <= locked_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
            period_q    <= period_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_early = err_early_q;
    assign err_late  = err_late_q;
    assign period    = period_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// tb/tb_pulse_period_monitor.sv - randomized self-checking bench for pulse_period_monitor
module tb_pulse_period_monitor;

    localparam int N        = 9;
    localparam int CBITS    = 4;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 3;
    localparam int MBITS    = 4;
    localparam int P        = N + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sig = 1'b0;
    logic             clr = 1'b0;
    logic             locked;
    logic             err_early;
    logic             err_late;
    logic [CBITS:0]   period;
    logic [MBITS-1:0] miss_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: timestamps of pulses rather than a counter.
    int cyc     = 0;
    int m_st    = 0;   // 0 searching, 1 acquiring, 2 locked
    int m_last  = 0;
    int m_good  = 0;
    int m_per   = 0;
    int m_miss  = 0;
    int m_ee    = 0;
    int m_el    = 0;

    pulse_period_monitor #(
        .N(N), .CBITS(CBITS), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .MBITS(MBITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig       (sig),
        .clr       (clr),
        .locked    (locked),
        .err_early (err_early),
        .err_late  (err_late),
        .period    (period),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model(input logic s, input logic c, input logic r);
        int iv;
        int early;
        int late;
        cyc++;
        early = 0;
        late  = 0;
        if (!r) begin
            m_st = 0; m_good = 0; m_per = 0; m_miss = 0; m_ee = 0; m_el = 0;
            return;
        end
        if (m_st == 0) begin
            if (s) begin
                m_st = 1; m_last = cyc; m_good = 0;
            end
        end else begin
            iv = cyc - m_last;
            if (s) begin
                m_per  = iv;
                m_last = cyc;
                if (iv >= P - TOL && iv <= P + TOL) begin
                    if (m_st == 1) begin
                        m_good++;
                        if (m_good == LOCK_CNT) begin
                            m_st = 2; m_good = 0;
                        end
                    end
                end else begin
                    if (m_st == 2 && iv < P - TOL) early = 1;
                    m_st = 1; m_good = 0;
                end
            end else if (iv > P + TOL) begin
                if (m_st == 2) late = 1;
                m_st = 0; m_good = 0;
            end
        end
        if (c) m_miss = 0;
        else if (late == 1 && m_miss < (1 << MBITS) - 1) m_miss++;
`ifdef PULSE_MON_STICKY_ERR_EN
        m_ee = (early == 1 || (m_ee == 1 && !c)) ? 1 : 0;
        m_el = (late == 1 || (m_el == 1 && !c)) ? 1 : 0;
`else
        m_ee = early;
        m_el = late;
`endif
    endtask

    task automatic step(input logic s, input logic c, input logic r);
        sig = s;
        clr = c;
        rst = r;
        @(posedge clk);
        model(s, c, r);
        #1;
        check("locked",    locked,    (m_st == 2) ? 1 : 0);
        check("err_early", err_early, m_ee);
        check("err_late",  err_late,  m_el);
        check("period",    period,    m_per);
        check("miss_cnt",  miss_cnt,  m_miss);
    endtask

    task automatic send(input int iv);
        repeat (iv - 1) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic lock_up();
        send(1);
        repeat (LOCK_CNT) send(P);
    endtask

    initial begin
        int iv;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("rst_locked", locked, 0);
        check("rst_period", period, 0);
        check("rst_miss",   miss_cnt, 0);

        send(3);
        send(P); send(P);
        check("pre_lock", locked, 0);
        send(P);
        check("nom_lock",   locked, 1);
        check("nom_period", period, P);

        send(P - TOL);
        send(P + TOL);
        check("edge_lock", locked, 1);
        check("edge_period", period, P + TOL);
        send(P - TOL - 1);
        check("early_strobe", err_early, 1);
        check("early_unlock", locked, 0);

        repeat (LOCK_CNT) send(P);
        check("relock", locked, 1);
        idle(P + TOL);
        check("no_late_yet", locked, 1);
        idle(1);
        check("late_strobe", err_late, 1);
        check("late_miss",   miss_cnt, 1);
        check("late_unlock", locked, 0);

        repeat (16) begin
            lock_up();
            idle(P + TOL + 1);
        end
        check("miss_sat", miss_cnt, (1 << MBITS) - 1);

        lock_up();
        idle(P + TOL);
        step(1'b0, 1'b1, 1'b1);
        check("clr_wins", miss_cnt, 0);
        check("clr_late", err_late, 1);

        lock_up();
        idle(6);
        step(1'b0, 1'b0, 1'b0);
        check("midrst_locked", locked, 0);
        check("midrst_period", period, 0);
        step(1'b0, 1'b0, 1'b1);

`ifdef PULSE_MON_STICKY_ERR_EN
        lock_up();
        send(P - TOL - 1);
        send(P); send(P);
        check("sticky_hold", err_early, 1);
        step(1'b0, 1'b1, 1'b1);
        check("sticky_clr", err_early, 0);
`endif

        for (int k = 0; k < 400; k++) begin
            iv = ($urandom_range(0, 9) == 0) ? 1 : int'($urandom_range(P - TOL - 2, P + TOL + 2));
            for (int j = 1; j <= iv; j++) begin
                step((j == iv) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_period_monitor.md
Name: pulse_period_monitor

Overview:
- Receive-side checker for the periodic `sig` pulse produced by the delay/period generator.
- Measures the cycle interval between successive pulses and acquires lock after a run of in-window periods.
- Once locked, flags early and late/missing pulses with 1-cycle error strobes and keeps a saturating miss count.
- Sits beside the generator in the same clock domain and feeds the system fault logic.

Parameters:
- N, 17500: generator terminal count. Nominal pulse period PERIOD = N+1 cycles (localparam).
- CBITS, 15: generator counter width. Monitor counter width is CBITS+1.
- TOL, 2: allowed deviation in cycles. Window is [PERIOD-TOL, PERIOD+TOL], inclusive at both ends.
- LOCK_CNT, 3: consecutive in-window intervals required to reach LOCKED.
- MBITS, 8: width of miss_cnt.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low.
- sig  input  1  pulse from generator; every cycle it is high counts as one pulse.
- clr  input  1  clears miss_cnt (and sticky errors when enabled).
- locked  output  1  high in LOCKED state.
- err_early  output  1  1-cycle strobe: pulse arrived before window while LOCKED.
- err_late  output  1  1-cycle strobe: window expired with no pulse while LOCKED.
- period  output  CBITS+1  last measured interval.
- miss_cnt  output  MBITS  saturating count of err_late events.

Behaviour:
- Reset (rst==0 at posedge): state=SEARCH; cnt=0; good=0; locked, err_early, err_late=0; period=0; miss_cnt=0.
- Interval counter `cnt`:
  - Held at 0 in SEARCH.
  - Otherwise, on a sig cycle the interval is cnt+1, then cnt<=0. On a non-sig cycle cnt<=cnt+1.
  - The interval is therefore the number of cycles from one pulse edge to the next; a generator at nominal rate gives exactly PERIOD.
  - cnt saturates at all-ones and never wraps.
- period updates with the interval on every sig cycle outside SEARCH. Latency is 1 cycle after the pulse.
- Timeout: state != SEARCH, sig==0, and cnt+1 > PERIOD+TOL.
- SEARCH:
  - sig -> ACQUIRE, cnt<=0, good<=0.
- ACQUIRE:
  - sig with interval in window: good<=good+1. If good+1==LOCK_CNT -> LOCKED, good<=0.
  - sig with interval outside window: good<=0, stay in ACQUIRE.
  - Timeout -> SEARCH, good<=0.
  - No error strobes in this state.
- LOCKED:
  - sig with interval in window: stay.
  - sig with interval < PERIOD-TOL: err_early=1 for 1 cycle -> ACQUIRE, good<=0. The new interval starts from this pulse.
  - Timeout: err_late=1 for 1 cycle, miss_cnt+1 (saturate at 2^MBITS-1) -> SEARCH.
- locked is registered and equals (state==LOCKED) on the same cycle as the state register.
- Boundaries:
  - An interval exactly PERIOD-TOL or PERIOD+TOL is in window.
  - sig held high for 2 cycles gives a second interval of 1, i.e. early.
  - clr and a miss event in the same cycle: clr wins, miss_cnt<=0.
  - rst low mid-interval aborts everything to reset values on that edge.
  - A sig arriving on the timeout cycle counts as a pulse, not a timeout.

Optional Feature:
- Macro: PULSE_MON_STICKY_ERR_EN.
- Defined: err_early and err_late are sticky. Each is set on its event and held until a cycle with clr==1 (or reset). If a new event and clr coincide, the event wins (flag stays 1).
- Undefined: err_early and err_late are 1-cycle strobes and clr affects only miss_cnt.

Decomposition:
- Package pulse_mon_pkg contains:
  - state enum {SEARCH, ACQUIRE, LOCKED}, 2 bits;
  - a function in_window(interval, PERIOD, TOL);
  - localparam PERIOD = N+1 is computed in the module from N.
- One sub-module is natural: pulse_interval_ctr.
  - Contents: the saturating counter plus interval capture.
  - Outputs: interval value, a pulse-seen flag and a timeout flag.
  - The FSM and miss counter stay in the top.

Test Plan:
(Use N=9, PERIOD=10, TOL=1, LOCK_CNT=3, MBITS=4.)
- Nominal lock: sig every 10 cycles after reset. locked=1 on the cycle after the 4th pulse, period=10, no error strobes.
- Window edges: intervals 9 and 11 while locked -> stay locked, no errors. Interval 8 -> err_early for 1 cycle, locked=0, state=ACQUIRE.
- Missing pulse: locked, then no sig -> err_late 1 cycle when cnt+1 reaches 12, miss_cnt=1, locked=0. Resume pulses every 10 -> relock after 4 pulses.
- Miss saturation and clr: 16 forced misses -> miss_cnt=15 (held). clr=1 on the same cycle as a miss -> miss_cnt=0.
- Reset mid-operation: drive rst=0 while locked at cnt=5 -> next edge: locked=0, period=0, miss_cnt=0, state=SEARCH.
- Sticky (with PULSE_MON_STICKY_ERR_EN): an early pulse sets err_early and it stays 1 across later pulses until clr=1 -> 0 on the next edge.
